// File: rtl/bit_serial_adder.sv
// bit_serial_adder: adds or subtracts two WIDTH-bit operands with a single
// full-adder slice. The slice is reused once per cycle, working LSB first.
// A start/done handshake frames each operation. The sum, cout and ovf
// registers update only when an operation completes.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             aBit, bBit, sBit, cBit, lastBit;
    logic [WIDTH:0]   resWide;

    // The shared full-adder slice sees the operand LSBs and the carry flop.
    assign aBit    = opA_q[0];
    assign bBit    = opB_q[0];
    assign sBit    = aBit ^ bBit ^ carry_q;
    assign cBit    = (aBit & bBit) | ((aBit ^ bBit) & carry_q);
    assign lastBit = (cnt_q == LAST_BIT);
    // Prepending the new bit and shifting right works even when WIDTH is 1.
    assign resWide = {sBit, res_q} >> 1;

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

    // State register; reset returns to IDLE, which aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, run WIDTH bit steps, pulse DONE once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (lastBit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: busy and done come straight from the state, so they never overlap.
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            RUN:     busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state: latch operands on accept, then run one adder step per RUN cycle.
    always_comb begin
        opA_d   = opA_q;
        opB_d   = opB_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    opA_d   = a_i;
                    opB_d   = sub_i ? ~b_i : b_i;
                    carry_d = sub_i ? 1'b1 : cin_i;
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                opA_d   = opA_q >> 1;
                opB_d   = opB_q >> 1;
                res_d   = resWide[WIDTH-1:0];
                carry_d = cBit;
                cnt_d   = cnt_q + CW'(1);
                if (lastBit) begin
                    // carry_q is the carry into the MSB at this step, so ovf
                    // comes from it and the carry out.
                    sum_d  = resWide[WIDTH-1:0];
                    cout_d = cBit;
                    ovf_d  = carry_q ^ cBit;
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers, all cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            opA_q   <= '0;
            opB_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed checks on an 8-bit adder plus randomized
// runs on 1-, 8- and 13-bit adders. Every cycle, each DUT is compared with an
// arithmetic model of when results must appear and what they must be.
`timescale 1ns/1ps
module tb_bit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int randFinishedCount = 0;

    // The model works in whole-operation arithmetic. k counts edges since the operation was accepted.
    typedef struct {
        logic        valid;
        logic        active;
        int          k;
        int          accepts;
        logic [15:0] pSum;
        logic        pCout;
        logic        pOvf;
        logic [15:0] eSum;
        logic        eCout;
        logic        eOvf;
        logic        eBusy;
        logic        eDone;
    } model_t;

    // Predict the outputs after the next rising edge, given the inputs applied to it.
    function automatic model_t modelStep(input model_t m, input int w, input logic rstn,
                                         input logic start, input logic sub, input logic cin,
                                         input logic [15:0] a, input logic [15:0] b);
        model_t n;
        longint unsigned mask, opA, opB, total;
        logic signA, signB, signS;
        n = m;
        n.valid = 1'b1;
        if (!rstn) begin
            n.active = 1'b0;
            n.k      = 0;
            n.eBusy  = 1'b0;
            n.eDone  = 1'b0;
            n.eSum   = '0;
            n.eCout  = 1'b0;
            n.eOvf   = 1'b0;
        end else if (m.active) begin
            n.k = m.k + 1;
            if (n.k == w) begin
                n.eBusy = 1'b0;
                n.eDone = 1'b1;
                n.eSum  = m.pSum;
                n.eCout = m.pCout;
                n.eOvf  = m.pOvf;
            end else if (n.k == w + 1) begin
                n.eDone  = 1'b0;
                n.active = 1'b0;
            end
        end else if (start) begin
            mask    = (64'd1 << w) - 64'd1;
            opA     = 64'(a) & mask;
            opB     = 64'(sub ? ~b : b) & mask;
            total   = opA + opB + 64'(sub ? 1'b1 : cin);
            signA   = ((opA >> (w - 1)) & 64'd1) != 64'd0;
            signB   = ((opB >> (w - 1)) & 64'd1) != 64'd0;
            signS   = ((total >> (w - 1)) & 64'd1) != 64'd0;
            n.pSum  = 16'(total & mask);
            n.pCout = ((total >> w) & 64'd1) != 64'd0;
            n.pOvf  = (signA == signB) && (signS != signA);
            n.active  = 1'b1;
            n.k       = 0;
            n.eBusy   = 1'b1;
            n.eDone   = 1'b0;
            n.accepts = m.accepts + 1;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, actual, expected, $time);
        else
            passes++;
    endtask

    task automatic checkSlot(input string tag, input model_t m, input logic busy, input logic done,
                             input logic [15:0] sum, input logic cout, input logic ovf);
        checkOutput({tag, " busy"}, 32'(busy), 32'(m.eBusy));
        checkOutput({tag, " done"}, 32'(done), 32'(m.eDone));
        checkOutput({tag, " sum"},  32'(sum),  32'(m.eSum));
        checkOutput({tag, " cout"}, 32'(cout), 32'(m.eCout));
        checkOutput({tag, " ovf"},  32'(ovf),  32'(m.eOvf));
    endtask

    // ---------------- directed 8-bit instance ----------------
    logic       dRstn, dStart, dSub, dCin;
    logic [7:0] dA, dB, dSum;
    logic       dBusy, dDone, dCout, dOvf;
    model_t     dModel = '{default: '0};

    bit_serial_adder #(.WIDTH(8)) dutDirected (
        .clk_i  (clk),
        .rst_ni (dRstn),
        .start_i(dStart),
        .sub_i  (dSub),
        .a_i    (dA),
        .b_i    (dB),
        .cin_i  (dCin),
        .busy_o (dBusy),
        .done_o (dDone),
        .sum_o  (dSum),
        .cout_o (dCout),
        .ovf_o  (dOvf)
    );

    // Compare the directed DUT with the model every cycle, then advance the model.
    always @(negedge clk) begin
        if (dModel.valid)
            checkSlot("dir", dModel, dBusy, dDone, 16'(dSum), dCout, dOvf);
        dModel = modelStep(dModel, 8, dRstn, dStart, dSub, dCin, 16'(dA), 16'(dB));
    end

    // Issue one operation, scramble the inputs after acceptance, and wait (bounded) for done.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                                 output int lat, output int busyCnt,
                                 output logic [7:0] s, output logic c, output logic o);
        @(posedge clk); #1;
        dA = a; dB = b; dCin = cin; dSub = sub; dStart = 1'b1;
        @(posedge clk); #1;
        dStart = 1'b0; dA = ~a; dB = a ^ 8'hA5; dCin = ~cin; dSub = ~sub;
        lat = 1;
        busyCnt = dBusy ? 1 : 0;
        while (!dDone && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (dBusy) busyCnt++;
        end
        checkOutput("dir done seen", 32'(dDone), 32'd1);
        s = dSum; c = dCout; o = dOvf;
    endtask

    int         lat, busyCnt, doneCount, firstDone, secondDone;
    logic [7:0] rs, seenSum;
    logic       rc, ro;
    model_t     zeroModel = '{default: '0};
    model_t     pin;

    initial begin
        dRstn = 1'b0; dStart = 1'b0; dSub = 1'b0; dCin = 1'b0; dA = '0; dB = '0;

        // Hand-computed values that pin the reference model itself.
        pin = modelStep(zeroModel, 8, 1'b1, 1'b1, 1'b0, 1'b0, 16'h005A, 16'h003C);
        checkOutput("model 5A+3C sum", 32'(pin.pSum), 32'h96);
        checkOutput("model 5A+3C ovf", 32'(pin.pOvf), 32'd1);
        pin = modelStep(zeroModel, 1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0001);
        checkOutput("model w1 1+1+1", 32'({pin.pCout, pin.pOvf, pin.pSum}), 32'h20001);
        pin = modelStep(zeroModel, 13, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001);
        checkOutput("model w13 0-1", 32'({pin.pCout, pin.pOvf, pin.pSum}), 32'h01FFF);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(dBusy), 32'd0);
        checkOutput("reset done", 32'(dDone), 32'd0);
        checkOutput("reset sum",  32'(dSum),  32'd0);
        checkOutput("reset cout", 32'(dCout), 32'd0);
        checkOutput("reset ovf",  32'(dOvf),  32'd0);
        dRstn = 1'b1;

        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0, lat, busyCnt, rs, rc, ro);
        checkOutput("5A+3C latency", 32'(lat), 32'd9);
        checkOutput("5A+3C busy cycles", 32'(busyCnt), 32'd8);
        checkOutput("5A+3C sum", 32'(rs), 32'h96);
        checkOutput("5A+3C cout", 32'(rc), 32'd0);
        checkOutput("5A+3C ovf", 32'(ro), 32'd1);

        applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0, lat, busyCnt, rs, rc, ro);
        checkOutput("FF+00+1", 32'({rc, ro, rs}), 32'h200);
        applyStimulus(8'h7F, 8'h00, 1'b1, 1'b0, lat, busyCnt, rs, rc, ro);
        checkOutput("7F+00+1", 32'({rc, ro, rs}), 32'h180);
        applyStimulus(8'h10, 8'h20, 1'b1, 1'b1, lat, busyCnt, rs, rc, ro);
        checkOutput("10-20", 32'({rc, ro, rs}), 32'h0F0);
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, lat, busyCnt, rs, rc, ro);
        checkOutput("80-01", 32'({rc, ro, rs}), 32'h37F);

        // Start pulses during RUN and during DONE must be ignored.
        @(posedge clk); #1;
        dA = 8'h11; dB = 8'h22; dCin = 1'b0; dSub = 1'b0; dStart = 1'b1;
        doneCount = 0; seenSum = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            dStart = 1'b0;
            if (i == 3) begin dStart = 1'b1; dA = 8'h01; dB = 8'h01; end
            if (dDone) begin
                doneCount++;
                seenSum = dSum;
                dStart = 1'b1; dA = 8'h02; dB = 8'h02;
            end
        end
        dStart = 1'b0;
        checkOutput("ignore start done count", 32'(doneCount), 32'd1);
        checkOutput("ignore start sum", 32'(seenSum), 32'h33);

        // Holding start high repeats an operation every WIDTH+2 cycles.
        @(posedge clk); #1;
        dA = 8'h21; dB = 8'h12; dStart = 1'b1;
        doneCount = 0; firstDone = 0; secondDone = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (dDone) begin
                if (doneCount == 0) firstDone = e;
                else if (doneCount == 1) secondDone = e;
                doneCount++;
            end
        end
        dStart = 1'b0;
        checkOutput("held start done count", 32'(doneCount), 32'd3);
        checkOutput("held start period", 32'(secondDone - firstDone), 32'd10);

        // Reset on the third RUN edge aborts the operation.
        @(posedge clk); #1;
        dA = 8'h5A; dB = 8'h3C; dCin = 1'b0; dSub = 1'b0; dStart = 1'b1;
        @(posedge clk); #1;
        dStart = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dRstn = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort busy", 32'(dBusy), 32'd0);
        checkOutput("abort done", 32'(dDone), 32'd0);
        checkOutput("abort result", 32'({dCout, dOvf, dSum}), 32'd0);
        dRstn = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (dDone) doneCount++;
        end
        checkOutput("abort no done", 32'(doneCount), 32'd0);
        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0, lat, busyCnt, rs, rc, ro);
        checkOutput("after abort 5A+3C", 32'({rc, ro, rs}), 32'h196);

        // Start on the same edge as reset must not be latched.
        @(posedge clk); #1;
        dRstn = 1'b0; dStart = 1'b1; dA = 8'h44; dB = 8'h44;
        @(posedge clk); #1;
        checkOutput("reset+start busy", 32'(dBusy), 32'd0);
        dRstn = 1'b1; dStart = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset+start still idle", 32'(dBusy), 32'd0);

        for (int i = 0; i < 60000 && randFinishedCount < 3; i++) @(posedge clk);
        checkOutput("random slots finished", 32'(randFinishedCount), 32'd3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // ---------------- randomized instances of several widths ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : randSlot
        localparam int W = (gi == 0) ? 1 : (gi == 1) ? 8 : 13;

        logic         rstn, start, sub, cin;
        logic [W-1:0] a, b, sum;
        logic         busy, done, cout, ovf;
        model_t       m = '{default: '0};
        int           cyc;

        bit_serial_adder #(.WIDTH(W)) dut (
            .clk_i  (clk),
            .rst_ni (rstn),
            .start_i(start),
            .sub_i  (sub),
            .a_i    (a),
            .b_i    (b),
            .cin_i  (cin),
            .busy_o (busy),
            .done_o (done),
            .sum_o  (sum),
            .cout_o (cout),
            .ovf_o  (ovf)
        );

        // Compare this DUT with the model every cycle, then advance the model.
        always @(negedge clk) begin
            if (m.valid)
                checkSlot($sformatf("w%0d", W), m, busy, done, 16'(sum), cout, ovf);
            m = modelStep(m, W, rstn, start, sub, cin, 16'(a), 16'(b));
        end

        // Random operands every cycle, random start pulses and occasional resets.
        initial begin
            rstn = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
            repeat (2) @(posedge clk);
            #1;
            rstn = 1'b1;
            cyc = 0;
            while (m.accepts < 1000 && cyc < 40000) begin
                @(posedge clk); #1;
                cyc++;
                start = ($urandom_range(0, 3) != 0);
                sub   = 1'($urandom_range(0, 1));
                cin   = 1'($urandom_range(0, 1));
                a     = W'($urandom);
                b     = W'($urandom);
                rstn  = ($urandom_range(0, 499) != 0);
            end
            rstn = 1'b1;
            start = 1'b0;
            repeat (W + 4) @(posedge clk);
            checkOutput($sformatf("w%0d operations accepted", W), 32'(m.accepts >= 1000), 32'd1);
            randFinishedCount++;
        end
    end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Sequential controller that time-multiplexes one full-adder bit slice (s = a^b^cin, cout = (a&b)|((a^b)&cin)) across WIDTH cycles to add or subtract two WIDTH-bit operands. The datapath is LSB-first: operand shift registers feed one carry flip-flop. It sits wherever area matters more than latency, for example accumulators and checksum units. It presents a start/done handshake to its requester.

## Interface
Parameters:
- WIDTH, default 8: operand/result width in bits; legal range ≥ 1.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset (sampled on clk rising edge).
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = a+b+cin, 1 = a−b (b inverted, carry-in forced 1, cin ignored); latched with start.
- a  in  WIDTH  operand A; latched with start.
- b  in  WIDTH  operand B; latched with start.
- cin  in  1  carry-in for add; latched with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result register.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- The clock is clk. Reset is rst_n: synchronous, active-low. Every register takes its reset value at a rising edge with rst_n=0, and reset overrides all other inputs.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers/counter/carry=0.
- States:
  - IDLE: if start=1, latch a, (sub ? ~b : b), carry=(sub ? 1 : cin); clear bit counter; go to RUN.
  - RUN: each cycle, apply the full-adder equations to the operand LSBs and the carry flop. Shift the result bit into the MSB of an internal result shift register (shift right). Shift both operands right. Update carry. Increment the counter. Before processing bit WIDTH−1, capture the carry into the MSB for ovf. After bit WIDTH−1 is processed, go to DONE.
  - DONE: done=1 for exactly this cycle; next state IDLE.
- Output registers:
  - sum, cout and ovf are loaded from the internal result on the RUN→DONE edge only.
  - They hold through DONE, IDLE and the whole of any following RUN, until the next completion.
- Handshake:
  - start is ignored in RUN and DONE. No queuing.
  - Operand and sub inputs are sampled only on the accepting edge and may change afterwards.
- Width arithmetic:
  - Counter width is $clog2(WIDTH+1).
  - Results are modulo 2^WIDTH, with the carry/borrow reported on cout.
  - For WIDTH=1, ovf = carry-in XOR cout.

## Timing
- Let edge T accept start.
  - Edges T+1 … T+WIDTH process bits 0 … WIDTH−1.
  - busy=1 from after T through the edge T+WIDTH.
  - done=1 in the cycle after T+WIDTH, with sum/cout/ovf valid in the same cycle.
- Latency: start-accept edge to done = WIDTH+1 cycles.
- Earliest next accept is edge T+WIDTH+2. With start held high, operations repeat every WIDTH+2 cycles.
- busy and done are never high together. Exactly one done per accepted start unless reset intervenes.
- Reset mid-operation (RUN or DONE): at the next edge return to IDLE with all outputs 0. No done is produced for the aborted operation.
- start and rst_n=0 on the same edge: reset wins and nothing is latched.

## Test plan
- WIDTH=8, add: a=0x5A, b=0x3C, cin=0 → done 9 cycles after accept, sum=0x96, cout=0, ovf=1; busy high for exactly 8 cycles.
- Add with carry: a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, ovf=1.
- Subtract: sub=1, a=0x10, b=0x20, cin=1 (ignored) → sum=0xF0, cout=0, ovf=0. Then sub=1, a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
- Handshake:
  - Pulse start again during RUN and during DONE with different operands → ignored; one done, first result.
  - Hold start high for 30 cycles → accepts every 10 cycles.
  - Change a/b after accept → result unaffected.
- Reset: accept a=0x5A, b=0x3C, drive rst_n=0 on the 3rd RUN edge → next cycle busy=0, done=0, sum=0x00, cout=0, ovf=0. No done follows. A new start after release gives the correct result.
- Random: 1000 random a/b/cin/sub for WIDTH=1, 8 and 13 against a reference model (a + b + cin or a + ~b + 1). Check sum, cout, ovf, exact done cycle, and that sum holds between completions.
